// File: rtl/sqrt_prep.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_prep
// Function : bfloat16 operand preparation and special-case bypass for a Q1.8
//            sqrt / inverse-sqrt core. Define SQRT_PREP_DENORM_EN to
//            normalise denormals instead of flushing them to zero.
// Revision : 1.0
// ============================================================================

module sqrt_prep (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [15:0] op_a_i,
    input  logic        op_inv_i,
    input  logic        core_valid_i,
    output logic        DoSqrt_o,
    output logic        DoInvSqrt_o,
    output logic [8:0]  s_o,
    output logic        meta_valid_o,
    output logic [8:0]  meta_exp_o,
    output logic        meta_sign_o,
    output logic        meta_special_o,
    output logic [15:0] meta_special_val_o
);

    localparam logic [15:0]       c_qnan    = 16'h7FC0;
    localparam logic [14:0]       c_inf_mag = 15'h7F80;
    localparam logic signed [9:0] c_bias    = 10'sd127;
`ifdef SQRT_PREP_DENORM_EN
    localparam logic signed [9:0] c_emin    = -10'sd126;
`endif

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
`ifdef SQRT_PREP_DENORM_EN
        ST_NORM  = 3'd1,
`endif
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        in_ready_q, in_ready_d;
    logic        do_sqrt_q, do_sqrt_d;
    logic        do_inv_q, do_inv_d;
    logic [8:0]  s_q, s_d;
    logic        meta_valid_q, meta_valid_d;
    logic [8:0]  meta_exp_q, meta_exp_d;
    logic        meta_sign_q, meta_sign_d;
    logic        meta_special_q, meta_special_d;
    logic [15:0] meta_special_val_q, meta_special_val_d;
`ifdef SQRT_PREP_DENORM_EN
    logic [7:0]        m_q, m_d;
    logic signed [9:0] e_q, e_d;
    logic              inv_q, inv_d;
    logic [7:0]        w_m_sh;
    logic signed [9:0] w_e_dec;
`endif

    // Operand classification
    logic        w_sign;
    logic [7:0]  w_exp;
    logic [6:0]  w_frac;
    logic        w_exp_max, w_exp_zero, w_frac_zero;
    logic        w_is_nan, w_is_inf, w_is_zero, w_is_neg_nz, w_is_special;
    logic        w_is_denorm;
    logic [15:0] w_special_val;

    assign w_sign      = op_a_i[15];
    assign w_exp       = op_a_i[14:7];
    assign w_frac      = op_a_i[6:0];
    assign w_exp_max   = &w_exp;
    assign w_exp_zero  = ~|w_exp;
    assign w_frac_zero = ~|w_frac;
    assign w_is_nan    = w_exp_max & ~w_frac_zero;
    assign w_is_inf    = w_exp_max & w_frac_zero;
`ifdef SQRT_PREP_DENORM_EN
    assign w_is_zero   = w_exp_zero & w_frac_zero;
    assign w_is_denorm = w_exp_zero & ~w_frac_zero & ~w_sign;
`else
    // Denormals flush to a signed zero
    assign w_is_zero   = w_exp_zero;
    assign w_is_denorm = 1'b0;
`endif
    assign w_is_neg_nz  = w_sign & ~w_is_zero;
    assign w_is_special = w_is_nan | w_is_neg_nz | w_is_inf | w_is_zero;

    always_comb begin
        w_special_val = 16'h0000;
        if (w_is_nan || w_is_neg_nz) begin
            w_special_val = c_qnan;
        end else if (w_is_inf) begin
            w_special_val = op_inv_i ? 16'h0000 : {1'b0, c_inf_mag};
        end else if (w_is_zero) begin
            w_special_val = op_inv_i ? {w_sign, c_inf_mag} : {w_sign, 15'h0000};
        end
    end

    // Issue-side operand selection and exponent halving
    logic              iss_go;
    logic [7:0]        iss_m;
    logic signed [9:0] iss_e;
    logic              iss_inv;
    logic signed [9:0] e_adj, e_half, e_half_neg;

    always_comb begin
        state_d            = state_q;
        do_sqrt_d          = 1'b0;
        do_inv_d           = 1'b0;
        meta_valid_d       = 1'b0;
        s_d                = s_q;
        meta_exp_d         = meta_exp_q;
        meta_sign_d        = meta_sign_q;
        meta_special_d     = meta_special_q;
        meta_special_val_d = meta_special_val_q;
        iss_go             = 1'b0;
        iss_m              = 8'h00;
        iss_e              = 10'sd0;
        iss_inv            = 1'b0;
        e_adj              = 10'sd0;
        e_half             = 10'sd0;
        e_half_neg         = 10'sd0;
`ifdef SQRT_PREP_DENORM_EN
        m_d                = m_q;
        e_d                = e_q;
        inv_d              = inv_q;
        w_m_sh             = {m_q[6:0], 1'b0};
        w_e_dec            = e_q - 10'sd1;
`endif

        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    if (w_is_special) begin
                        meta_valid_d       = 1'b1;
                        meta_special_d     = 1'b1;
                        meta_special_val_d = w_special_val;
                        meta_sign_d        = w_special_val[15];
                        meta_exp_d         = 9'h000;
`ifdef SQRT_PREP_DENORM_EN
                    end else if (w_is_denorm) begin
                        state_d = ST_NORM;
                        m_d     = {1'b0, w_frac};
                        e_d     = c_emin;
                        inv_d   = op_inv_i;
`endif
                    end else begin
                        iss_go  = 1'b1;
                        iss_m   = {1'b1, w_frac};
                        iss_e   = $signed({2'b00, w_exp}) - c_bias;
                        iss_inv = op_inv_i;
                    end
                end
            end
`ifdef SQRT_PREP_DENORM_EN
            ST_NORM: begin
                m_d = w_m_sh;
                e_d = w_e_dec;
                // Issue on the shift that brings the leading one into m[7]
                if (w_m_sh[7]) begin
                    iss_go  = 1'b1;
                    iss_m   = w_m_sh;
                    iss_e   = w_e_dec;
                    iss_inv = inv_q;
                end
            end
`endif
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (core_valid_i) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (iss_go) begin
            state_d = ST_ISSUE;
            // Odd exponent: halve the mantissa so the exponent becomes even
            if (iss_e[0]) begin
                s_d   = {1'b0, iss_m};
                e_adj = iss_e + 10'sd1;
            end else begin
                s_d   = {iss_m, 1'b0};
                e_adj = iss_e;
            end
            e_half             = e_adj >>> 1;
            e_half_neg         = -e_half;
            meta_exp_d         = iss_inv ? e_half_neg[8:0] : e_half[8:0];
            do_sqrt_d          = ~iss_inv;
            do_inv_d           = iss_inv;
            meta_valid_d       = 1'b1;
            meta_special_d     = 1'b0;
            meta_special_val_d = 16'h0000;
            meta_sign_d        = 1'b0;
        end

        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= ST_IDLE;
            in_ready_q         <= 1'b1;
            do_sqrt_q          <= 1'b0;
            do_inv_q           <= 1'b0;
            s_q                <= 9'h000;
            meta_valid_q       <= 1'b0;
            meta_exp_q         <= 9'h000;
            meta_sign_q        <= 1'b0;
            meta_special_q     <= 1'b0;
            meta_special_val_q <= 16'h0000;
`ifdef SQRT_PREP_DENORM_EN
            m_q                <= 8'h00;
            e_q                <= 10'sd0;
            inv_q              <= 1'b0;
`endif
        end else begin
            state_q            <= state_d;
            in_ready_q         <= in_ready_d;
            do_sqrt_q          <= do_sqrt_d;
            do_inv_q           <= do_inv_d;
            s_q                <= s_d;
            meta_valid_q       <= meta_valid_d;
            meta_exp_q         <= meta_exp_d;
            meta_sign_q        <= meta_sign_d;
            meta_special_q     <= meta_special_d;
            meta_special_val_q <= meta_special_val_d;
`ifdef SQRT_PREP_DENORM_EN
            m_q                <= m_d;
            e_q                <= e_d;
            inv_q              <= inv_d;
`endif
        end
    end

    assign in_ready_o         = in_ready_q;
    assign DoSqrt_o           = do_sqrt_q;
    assign DoInvSqrt_o        = do_inv_q;
    assign s_o                = s_q;
    assign meta_valid_o       = meta_valid_q;
    assign meta_exp_o         = meta_exp_q;
    assign meta_sign_o        = meta_sign_q;
    assign meta_special_o     = meta_special_q;
    assign meta_special_val_o = meta_special_val_q;

endmodule

`default_nettype wire

// File: tb/tb_sqrt_prep.sv
`default_nettype none
// ============================================================================
// Module   : tb_sqrt_prep
// Function : Directed, table-driven self-checking bench for sqrt_prep.
// Revision : 1.0
// ============================================================================

module tb_sqrt_prep;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [15:0] op_a_i = 16'h0000;
    logic        op_inv_i = 1'b0;
    logic        core_valid_i = 1'b0;
    logic        DoSqrt_o, DoInvSqrt_o;
    logic [8:0]  s_o;
    logic        meta_valid_o;
    logic [8:0]  meta_exp_o;
    logic        meta_sign_o, meta_special_o;
    logic [15:0] meta_special_val_o;

    int n_checks = 0;
    int n_err    = 0;

    sqrt_prep dut (
        .clk                (clk),
        .rst                (rst),
        .in_valid_i         (in_valid_i),
        .in_ready_o         (in_ready_o),
        .op_a_i             (op_a_i),
        .op_inv_i           (op_inv_i),
        .core_valid_i       (core_valid_i),
        .DoSqrt_o           (DoSqrt_o),
        .DoInvSqrt_o        (DoInvSqrt_o),
        .s_o                (s_o),
        .meta_valid_o       (meta_valid_o),
        .meta_exp_o         (meta_exp_o),
        .meta_sign_o        (meta_sign_o),
        .meta_special_o     (meta_special_o),
        .meta_special_val_o (meta_special_val_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] op;
        logic        inv;
        int          lat;
        logic        special;
        logic [15:0] sval;
        logic        sign;
        logic [8:0]  s;
        logic [8:0]  mexp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [15:0] op, input logic inv, input int lat,
                                input logic special, input logic [15:0] sval,
                                input logic sign, input logic [8:0] s, input logic [8:0] mexp);
        vec_t v;
        v.op = op; v.inv = inv; v.lat = lat; v.special = special;
        v.sval = sval; v.sign = sign; v.s = s; v.mexp = mexp;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [15:0] act,
                         input logic [15:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s (case %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp_v);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cyc;
        @(negedge clk);
        check("ready_before", idx, in_ready_o, 1);
        in_valid_i = 1'b1;
        op_a_i     = v.op;
        op_inv_i   = v.inv;
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        op_a_i     = 16'h0000;
        op_inv_i   = 1'b0;
        cyc = 1;
        @(negedge clk);
        while (!meta_valid_o && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", idx, cyc, v.lat);
        check("meta_valid", idx, meta_valid_o, 1);
        check("meta_special", idx, meta_special_o, v.special);
        check("meta_special_val", idx, meta_special_val_o, v.sval);
        check("meta_sign", idx, meta_sign_o, v.sign);
        if (v.special) begin
            check("DoSqrt_special", idx, DoSqrt_o, 0);
            check("DoInvSqrt_special", idx, DoInvSqrt_o, 0);
            check("ready_special", idx, in_ready_o, 1);
        end else begin
            check("DoSqrt", idx, DoSqrt_o, !v.inv);
            check("DoInvSqrt", idx, DoInvSqrt_o, v.inv);
            check("s_o", idx, s_o, v.s);
            check("meta_exp", idx, meta_exp_o, v.mexp);
            check("ready_issue", idx, in_ready_o, 0);
            @(negedge clk);
            check("pulse_drop", idx, DoSqrt_o | DoInvSqrt_o | meta_valid_o, 0);
            check("s_hold", idx, s_o, v.s);
            check("ready_wait", idx, in_ready_o, 0);
            core_valid_i = 1'b1;
            @(negedge clk);
            core_valid_i = 1'b0;
            check("ready_drain", idx, in_ready_o, 0);
            @(negedge clk);
            check("ready_after_done", idx, in_ready_o, 1);
            check("meta_exp_hold", idx, meta_exp_o, v.mexp);
        end
    endtask

    initial begin
        vecs.push_back(mk(16'h4080, 1'b0, 1, 1'b0, 16'h0000, 1'b0, 9'h100, 9'h001));
        vecs.push_back(mk(16'h4000, 1'b1, 1, 1'b0, 16'h0000, 1'b0, 9'h080, 9'h1FF));
        vecs.push_back(mk(16'hC080, 1'b1, 1, 1'b1, 16'h7FC0, 1'b0, 9'h000, 9'h000));
        vecs.push_back(mk(16'h0000, 1'b1, 1, 1'b1, 16'h7F80, 1'b0, 9'h000, 9'h000));
        vecs.push_back(mk(16'h0000, 1'b0, 1, 1'b1, 16'h0000, 1'b0, 9'h000, 9'h000));
        vecs.push_back(mk(16'h8000, 1'b0, 1, 1'b1, 16'h8000, 1'b1, 9'h000, 9'h000));
        vecs.push_back(mk(16'h8000, 1'b1, 1, 1'b1, 16'hFF80, 1'b1, 9'h000, 9'h000));
        vecs.push_back(mk(16'h7F80, 1'b0, 1, 1'b1, 16'h7F80, 1'b0, 9'h000, 9'h000));
        vecs.push_back(mk(16'h7F80, 1'b1, 1, 1'b1, 16'h0000, 1'b0, 9'h000, 9'h000));
        vecs.push_back(mk(16'h7FC1, 1'b0, 1, 1'b1, 16'h7FC0, 1'b0, 9'h000, 9'h000));
        vecs.push_back(mk(16'hFFC0, 1'b1, 1, 1'b1, 16'h7FC0, 1'b0, 9'h000, 9'h000));
        vecs.push_back(mk(16'hBF80, 1'b0, 1, 1'b1, 16'h7FC0, 1'b0, 9'h000, 9'h000));
        vecs.push_back(mk(16'hFF80, 1'b1, 1, 1'b1, 16'h7FC0, 1'b0, 9'h000, 9'h000));
        vecs.push_back(mk(16'h3F80, 1'b0, 1, 1'b0, 16'h0000, 1'b0, 9'h100, 9'h000));
        vecs.push_back(mk(16'h3FC0, 1'b1, 1, 1'b0, 16'h0000, 1'b0, 9'h180, 9'h000));
        vecs.push_back(mk(16'h7F7F, 1'b0, 1, 1'b0, 16'h0000, 1'b0, 9'h0FF, 9'h040));
        vecs.push_back(mk(16'h0080, 1'b1, 1, 1'b0, 16'h0000, 1'b0, 9'h100, 9'h03F));
        vecs.push_back(mk(16'h0080, 1'b0, 1, 1'b0, 16'h0000, 1'b0, 9'h100, 9'h1C1));
        vecs.push_back(mk(16'h4100, 1'b0, 1, 1'b0, 16'h0000, 1'b0, 9'h080, 9'h002));
        vecs.push_back(mk(16'h4100, 1'b1, 1, 1'b0, 16'h0000, 1'b0, 9'h080, 9'h1FE));
`ifdef SQRT_PREP_DENORM_EN
        vecs.push_back(mk(16'h0001, 1'b0, 8, 1'b0, 16'h0000, 1'b0, 9'h080, 9'h1BE));
        vecs.push_back(mk(16'h0040, 1'b1, 2, 1'b0, 16'h0000, 1'b0, 9'h080, 9'h03F));
        vecs.push_back(mk(16'h8001, 1'b0, 1, 1'b1, 16'h7FC0, 1'b0, 9'h000, 9'h000));
`else
        vecs.push_back(mk(16'h0001, 1'b0, 1, 1'b1, 16'h0000, 1'b0, 9'h000, 9'h000));
        vecs.push_back(mk(16'h0040, 1'b1, 1, 1'b1, 16'h7F80, 1'b0, 9'h000, 9'h000));
        vecs.push_back(mk(16'h8001, 1'b0, 1, 1'b1, 16'h8000, 1'b1, 9'h000, 9'h000));
`endif

        // Reset state
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 0, in_ready_o, 1);
        check("rst_pulses", 0, DoSqrt_o | DoInvSqrt_o | meta_valid_o, 0);
        check("rst_s", 0, s_o, 0);
        check("rst_meta", 0, {meta_sign_o, meta_special_o, meta_exp_o}, 0);
        check("rst_special_val", 0, meta_special_val_o, 0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(i, vecs[i]);
        end

        // in_valid held through the whole operation; core_valid outside WAIT ignored
        @(negedge clk);
        in_valid_i = 1'b1; op_a_i = 16'h4080; op_inv_i = 1'b0;
        @(negedge clk);
        check("hold_issue_pulse", 100, DoSqrt_o, 1);
        op_a_i = 16'hC080;
        core_valid_i = 1'b1;
        @(negedge clk);
        core_valid_i = 1'b0;
        check("hold_wait_ready", 100, in_ready_o, 0);
        check("hold_wait_meta", 100, meta_valid_o | DoSqrt_o, 0);
        @(negedge clk);
        check("hold_still_wait", 100, in_ready_o, 0);
        check("hold_no_accept", 100, meta_valid_o, 0);
        check("hold_s", 100, s_o, 9'h100);
        core_valid_i = 1'b1;
        @(negedge clk);
        core_valid_i = 1'b0;
        in_valid_i = 1'b0;
        op_a_i = 16'h0000;
        @(negedge clk);
        check("hold_ready_back", 100, in_ready_o, 1);
        check("hold_meta_kept", 100, meta_special_o, 0);

        // Reset while waiting on the core
        in_valid_i = 1'b1; op_a_i = 16'h4000; op_inv_i = 1'b1;
        @(negedge clk);
        in_valid_i = 1'b0;
        check("rstw_issue", 101, DoInvSqrt_o, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstw_ready", 101, in_ready_o, 1);
        check("rstw_pulses", 101, DoSqrt_o | DoInvSqrt_o | meta_valid_o, 0);
        check("rstw_s", 101, s_o, 0);
        check("rstw_exp", 101, meta_exp_o, 0);

        // Reset in ISSUE removes the visible pulse on the following cycle
        in_valid_i = 1'b1; op_a_i = 16'h4080; op_inv_i = 1'b0;
        @(negedge clk);
        in_valid_i = 1'b0;
        check("rsti_issue", 102, DoSqrt_o, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rsti_pulses", 102, DoSqrt_o | DoInvSqrt_o | meta_valid_o, 0);
        check("rsti_ready", 102, in_ready_o, 1);

        // Normal operation resumes after the aborts
        run_vec(0, vecs[0]);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sqrt_prep.md
SQRT_PREP -- requirements
Module: sqrt_prep

Interface
REQ-001 clk  in  1  rising-edge clock.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 in_valid_i  in  1  operand request.
REQ-004 in_ready_o  out  1  block can accept an operand.
REQ-005 op_a_i  in  16  bfloat16 operand: sign[15], exp[14:7], frac[6:0].
REQ-006 op_inv_i  in  1  0 = sqrt, 1 = inverse sqrt; sampled with op_a_i.
REQ-007 core_valid_i  in  1  one-cycle done pulse from the downstream sqrt core.
REQ-008 DoSqrt_o / DoInvSqrt_o  out  1 each  one-cycle start pulses to the core; never both high.
REQ-009 s_o  out  9  Q1.8 core operand; held stable from the start pulse until core_valid_i.
REQ-010 meta_valid_o  out  1  one-cycle pulse qualifying the meta_* outputs.
REQ-011 meta_exp_o  out  9  signed unbiased result exponent (two's complement).
REQ-012 meta_sign_o, meta_special_o  out  1 each  result sign; special-case flag (core bypassed).
REQ-013 meta_special_val_o  out  16  final bfloat16 result when meta_special_o=1; else 0.

Function
REQ-014 States: IDLE, NORM, ISSUE, WAIT, DRAIN; in_ready_o=1 only in IDLE.
REQ-015 Acceptance: in_valid_i & in_ready_o on a rising edge; op_a_i and op_inv_i are registered.
REQ-016 Special classes, decided at acceptance, SHALL stay in IDLE, skip the core and pulse meta_valid_o with meta_special_o=1 on the next cycle.
REQ-016a Special results: NaN -> 0x7FC0; negative nonzero -> 0x7FC0; +inf -> sqrt 0x7F80, inv 0x0000; +/-0 -> sqrt same signed zero, inv same-signed inf (0x7F80/0xFF80).
REQ-017 Normal operand, exp 1..254: mantissa m = {1,frac}; e = exp-127.
REQ-017a Normal operand, even e: s_o = {m,0}; odd e: s_o = {0,m} and e := e+1.
REQ-017b Normal operand exponent output: meta_exp_o = e/2 for sqrt, -(e/2) for inverse.
REQ-018 Normal path: IDLE -> ISSUE; in ISSUE, pulse DoSqrt_o (op_inv=0) or DoInvSqrt_o (op_inv=1), pulse meta_valid_o with meta_special_o=0, then go to WAIT.
REQ-019 Start-pulse latency: exactly 1 cycle after acceptance for normal operands.
REQ-020 WAIT -> DRAIN on core_valid_i; DRAIN -> IDLE unconditionally, covering the core's one-cycle post-done recovery.
REQ-020a Ready latency: in_ready_o reasserts 2 cycles after core_valid_i.
REQ-021 Ignored inputs: in_valid_i outside IDLE; core_valid_i outside WAIT.
REQ-022 meta_sign_o = 0 for every non-special result.
REQ-023 All meta_* outputs are registered and SHALL hold their value until the next meta_valid_o.

Reset
REQ-024 Under rst: state IDLE; all outputs 0 except in_ready_o, which SHALL be 1 from the first cycle after reset.
REQ-025 rst asserted in any state SHALL abort the operation with no pulse emitted; the core is reset by the same rst.

Configuration
REQ-026 Macro SQRT_PREP_DENORM_EN defined: exp=0, frac!=0 (sign 0) enters NORM.
REQ-026a NORM behaviour: m = {0,frac}, e = -126; shift m left by 1 and decrement e once per cycle until m[7]=1.
REQ-026b NORM exit: go to ISSUE and apply the parity rule of REQ-017a; latency grows by the number of shifts (1..7).
REQ-027 Macro undefined: denormals are flushed to signed zero and handled per REQ-016a; the NORM state is not implemented.

Verification
REQ-028 sqrt 0x4080 (4.0) -> DoSqrt_o pulse 1 cycle after acceptance, s_o=0x100, meta_exp_o=+1.
REQ-028a Completion handshake for the REQ-028 case: core_valid_i, then in_ready_o=1 two cycles later.
REQ-029 inverse 0x4000 (2.0) -> DoInvSqrt_o pulse, s_o=0x080, meta_exp_o=-1, DoSqrt_o stays 0.
REQ-030 inverse 0xC080 (-4.0) -> no start pulse; meta_special_o=1, meta_special_val_o=0x7FC0 1 cycle after acceptance.
REQ-030a inverse 0x0000 -> meta_special_val_o=0x7F80.
REQ-031 sqrt 0x0001 with SQRT_PREP_DENORM_EN -> 7 NORM cycles, then s_o=0x080, meta_exp_o=-66 (0x1BE).
REQ-031a sqrt 0x0001 without the macro -> special 0x0000.
REQ-032 in_valid_i held high during WAIT is not accepted; rst asserted in WAIT -> in_ready_o=1 and no pulses on the next cycle.
